mem_responder: RTL and testbench

Bus responder for the multicycle CPU: it accepts single-word, halfword or byte memory requests from an initiator, inserts a parameterised number of wait states, and answers with a one-cycle acknowledge plus read data or an error flag. It lets the control unit be exercised against variable-latency memory and is the target end of the CPU's request/acknowledge data-memory interface.

---
 rtl/mem_responder_if.sv | 40 ++++
 rtl/mem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_responder_if                                           |
// | Description : Request/acknowledge data-memory bus between an initiator   |
// |               (master) and a memory responder (slave).                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Signals                                                                  |
// |   req   : request strobe (initiator -> responder)                        |
// |   we    : 1 = write, 0 = read                                            |
// |   size  : 00 word, 01 halfword, 10 byte, 11 illegal                      |
// |   addr  : byte address, little-endian lanes                              |
// |   wdata : write data (halfword in [15:0], byte in [7:0])                 |
// |   rdata : read data, zero-extended for sub-word reads                    |
// |   ack   : one-cycle completion pulse                                     |
// |   err   : request rejected (qualified by ack)                            |
// |   busy  : responder owns a request (acceptance through ack cycle)        |
// +--------------------------------------------------------------------------+
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  modport master (
    output req, we, size, addr, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, size, addr, wdata,
    output rdata, ack, err, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_responder                                              |
// | Description : Memory bus responder with programmable wait states.        |
// |               Accepts word/halfword/byte requests, waits WAIT cycles,    |
// |               then answers with a one-cycle ack plus read data, or with  |
// |               ack+err one cycle after acceptance for illegal requests.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   DEPTH_WORDS : 32-bit words of storage (power of two, >= 4)             |
// |   WAIT        : wait states between acceptance and ack (0..15)           |
// | Ports                                                                    |
// |   clk   : clock, rising edge                                             |
// |   reset : asynchronous active-low reset of all control state             |
// |   bus   : slave side of mem_responder_if                                 |
// +--------------------------------------------------------------------------+
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT        = 2
) (
  input wire             clk,
  input wire             reset,
  mem_responder_if.slave bus
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          arm_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          ack_q;
  logic          err_q;
  logic          busy_q;
  logic [31:0]   rdata_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          req_illegal;
  logic [31:0]   rd_in_d;
  logic [31:0]   rd_lat_d;
  logic [31:0]   cur_word;
  logic [31:0]   wr_word_d;
  logic          mem_we;

  // Select and zero-extend the addressed lane(s) of a storage word.
  function automatic logic [31:0] fmt_read(input logic [31:0] word,
                                           input logic [1:0]  sz,
                                           input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    case (sz)
      2'b01: r = lane[1] ? {16'h0000, word[31:16]} : {16'h0000, word[15:0]};
      2'b10: begin
        case (lane)
          2'd0:    r = {24'h000000, word[7:0]};
          2'd1:    r = {24'h000000, word[15:8]};
          2'd2:    r = {24'h000000, word[23:16]};
          default: r = {24'h000000, word[31:24]};
        endcase
      end
      default: r = word;
    endcase
    return r;
  endfunction

  // Because DEPTH_WORDS is a power of two, an out-of-range word index is
  // exactly "any address bit above the storage index is set".
  always_comb begin
    req_illegal = |bus.addr[31:AW+2];
    case (bus.size)
      2'b00:   if (bus.addr[1:0] != 2'b00) req_illegal = 1'b1;
      2'b01:   if (bus.addr[0]) req_illegal = 1'b1;
      2'b10:   req_illegal = req_illegal;
      default: req_illegal = 1'b1;
    endcase
  end

  // Read data is captured on the edge that enters the ack cycle, so it is
  // valid together with ack. With zero wait states that edge is the accepting
  // edge itself, hence the path straight from the bus inputs.
  assign rd_in_d  = fmt_read(mem[bus.addr[AW+1:2]], bus.size, bus.addr[1:0]);
  assign rd_lat_d = fmt_read(mem[addr_q[AW+1:2]], size_q, addr_q[1:0]);

  // Read-modify-write merge: only the addressed lanes take new data.
  assign cur_word = mem[addr_q[AW+1:2]];

  always_comb begin
    wr_word_d = cur_word;
    case (size_q)
      2'b01: begin
        if (addr_q[1]) wr_word_d[31:16] = wdata_q[15:0];
        else           wr_word_d[15:0]  = wdata_q[15:0];
      end
      2'b10: begin
        case (addr_q[1:0])
          2'd0:    wr_word_d[7:0]   = wdata_q[7:0];
          2'd1:    wr_word_d[15:8]  = wdata_q[7:0];
          2'd2:    wr_word_d[23:16] = wdata_q[7:0];
          default: wr_word_d[31:24] = wdata_q[7:0];
        endcase
      end
      default: wr_word_d = wdata_q;
    endcase
  end

  // The write commits at the edge that closes the ack cycle. Reset forces the
  // state to idle asynchronously, which is what discards an aborted write.
  assign mem_we = (state_q == ST_RESP) && we_q && !err_q;

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q[AW+1:2]] <= wr_word_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      arm_q   <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      // arm_q blocks acceptance on the first edge after reset release.
      arm_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (arm_q && bus.req) begin
            we_q    <= bus.we;
            size_q  <= bus.size;
            addr_q  <= bus.addr[AW+1:0];
            wdata_q <= bus.wdata;
            busy_q  <= 1'b1;
            if (req_illegal) begin
              state_q <= ST_RESP;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
            end else if (WAIT == 0) begin
              state_q <= ST_RESP;
              ack_q   <= 1'b1;
              err_q   <= 1'b0;
              if (!bus.we) rdata_q <= rd_in_d;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_CNT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q <= 4'd1) begin
            state_q <= ST_RESP;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b1;
            err_q   <= 1'b0;
            if (!we_q) rdata_q <= rd_lat_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_responder                                           |
// | Description : Bench for mem_responder. Two responders (WAIT=2, WAIT=0)   |
// |               share one initiator stimulus; a transaction-level model    |
// |               predicts ack/err/busy/rdata for each, every cycle.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_responder;

  localparam int DEPTH = 16;
  localparam int NDUT  = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [1:0]  size  = 2'b00;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;

  int checks = 0;
  int errors = 0;

  mem_responder_if if2();
  mem_responder_if if0();

  assign if2.req = req;  assign if2.we = we;  assign if2.size = size;
  assign if2.addr = addr; assign if2.wdata = wdata;
  assign if0.req = req;  assign if0.we = we;  assign if0.size = size;
  assign if0.addr = addr; assign if0.wdata = wdata;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));
  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT(0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));

  always #5 clk = ~clk;

  // Observed outputs, index 0 = WAIT=2 responder, index 1 = WAIT=0 responder
  logic        act_ack [NDUT];
  logic        act_err [NDUT];
  logic        act_busy[NDUT];
  logic [31:0] act_rd  [NDUT];
  assign act_ack[0] = if2.ack;  assign act_ack[1] = if0.ack;
  assign act_err[0] = if2.err;  assign act_err[1] = if0.err;
  assign act_busy[0] = if2.busy; assign act_busy[1] = if0.busy;
  assign act_rd[0] = if2.rdata; assign act_rd[1] = if0.rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int unsigned waitv [NDUT] = '{2, 0};
  logic [31:0] mmem  [NDUT][DEPTH];
  bit          m_ack [NDUT];
  bit          m_err [NDUT];
  bit          m_busy[NDUT];
  logic [31:0] m_rd  [NDUT] = '{32'h0, 32'h0};
  longint      m_ack_at[NDUT];
  bit          p_we  [NDUT];
  logic [1:0]  p_size[NDUT];
  logic [31:0] p_addr[NDUT];
  logic [31:0] p_wd  [NDUT];
  bit          m_armed = 1'b0;
  longint      cyc = 0;

  function automatic bit model_bad(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd3) || (s == 2'd0 && a % 4 != 0) || (s == 2'd1 && a % 2 != 0) ||
           (a / 4 >= DEPTH);
  endfunction

  function automatic logic [31:0] width_mask(input logic [1:0] s);
    return (s == 2'd0) ? 32'hFFFF_FFFF : (s == 2'd1) ? 32'h0000_FFFF : 32'h0000_00FF;
  endfunction

  function automatic logic [31:0] model_read(input int d);
    logic [31:0] w;
    w = mmem[d][p_addr[d] / 4] >> (8 * (p_addr[d] % 4));
    return w & width_mask(p_size[d]);
  endfunction

  function automatic void model_write(input int d);
    logic [31:0] mask, val;
    int          sh;
    sh   = 8 * int'(p_addr[d] % 4);
    mask = width_mask(p_size[d]);
    val  = (p_wd[d] & mask) << sh;
    mask = mask << sh;
    mmem[d][p_addr[d] / 4] = (mmem[d][p_addr[d] / 4] & ~mask) | val;
  endfunction

  initial begin
    for (int d = 0; d < NDUT; d++)
      for (int w = 0; w < DEPTH; w++) mmem[d][w] = 32'h0;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < NDUT; d++) begin
        m_ack[d] = 1'b0; m_err[d] = 1'b0; m_busy[d] = 1'b0; m_rd[d] = 32'h0;
      end
      m_armed = 1'b0;
    end else begin
      cyc++;
      for (int d = 0; d < NDUT; d++) begin
        if (m_ack[d]) begin
          if (!m_err[d] && p_we[d]) model_write(d);
          m_ack[d] = 1'b0; m_err[d] = 1'b0; m_busy[d] = 1'b0;
        end else if (m_busy[d]) begin
          if (cyc == m_ack_at[d]) begin
            m_ack[d] = 1'b1;
            if (!p_we[d]) m_rd[d] = model_read(d);
          end
        end else if (m_armed && req) begin
          p_we[d] = we; p_size[d] = size; p_addr[d] = addr; p_wd[d] = wdata;
          m_busy[d] = 1'b1;
          if (model_bad(size, addr)) begin
            m_ack[d] = 1'b1; m_err[d] = 1'b1;
          end else if (waitv[d] == 0) begin
            m_ack[d] = 1'b1;
            if (!we) m_rd[d] = model_read(d);
          end else begin
            m_ack_at[d] = cyc + longint'(waitv[d]);
          end
        end
      end
      m_armed = 1'b1;
    end
  end

  // Per-cycle comparison, well clear of both clock edges
  always @(posedge clk) begin
    #3;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("d%0d.ack", d), 32'(act_ack[d]), 32'(m_ack[d]));
      check($sformatf("d%0d.busy", d), 32'(act_busy[d]), 32'(m_busy[d]));
      check($sformatf("d%0d.rdata", d), act_rd[d], m_rd[d]);
      if (m_ack[d]) check($sformatf("d%0d.err", d), 32'(act_err[d]), 32'(m_err[d]));
    end
  end

  // ---------------- directed helpers ----------------
  // Issue one request and wait (bounded) for the WAIT=2 responder's ack.
  task automatic do_req(input bit w, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic e, output logic a0);
    @(negedge clk);
    req = 1'b1; we = w; size = s; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    a0  = if0.ack;
    while (if2.ack !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = if2.rdata;
    e  = if2.err;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, acks2, acks0, first2, second2, cnt;
    logic [31:0] rd;
    logic        e, a0;
    logic [31:0] bad_addr [4];
    logic [1:0]  bad_size [4];
    bit          bad_we   [4];

    repeat (3) @(negedge clk);
    check("rst.ack", 32'(if2.ack), 0);
    check("rst.err", 32'(if2.err), 0);
    check("rst.busy", 32'(if2.busy), 0);
    check("rst.rdata", if2.rdata, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) do_req(1'b1, 2'd0, 32'(4 * i), $urandom, lat, rd, e, a0);

    do_req(1'b1, 2'd0, 32'h10, 32'hDEADBEEF, lat, rd, e, a0);
    check("wr.lat", 32'(lat), 3);
    check("wr.err", 32'(e), 0);
    check("wr.ack0_lat1", 32'(a0), 1);
    do_req(1'b0, 2'd0, 32'h10, 32'h0, lat, rd, e, a0);
    check("rd.lat", 32'(lat), 3);
    check("rd.data", rd, 32'hDEADBEEF);
    check("rd.ack0_lat1", 32'(a0), 1);

    do_req(1'b1, 2'd2, 32'h11, 32'hFFFF_FFAA, lat, rd, e, a0);
    do_req(1'b1, 2'd1, 32'h12, 32'hABCD_1234, lat, rd, e, a0);
    do_req(1'b0, 2'd0, 32'h10, 32'h0, lat, rd, e, a0);
    check("lanes.word", rd, 32'h1234AAEF);
    do_req(1'b0, 2'd2, 32'h13, 32'h0, lat, rd, e, a0);
    check("lanes.byte", rd, 32'h00000012);
    do_req(1'b1, 2'd0, 32'h00, 32'h11223344, lat, rd, e, a0);

    bad_we   = '{1'b1, 1'b0, 1'b0, 1'b0};
    bad_size = '{2'd0, 2'd1, 2'd3, 2'd0};
    bad_addr = '{32'h02, 32'h05, 32'h00, 32'(4 * DEPTH)};
    for (int i = 0; i < 4; i++) begin
      do_req(bad_we[i], bad_size[i], bad_addr[i], 32'hFFFF_FFFF, lat, rd, e, a0);
      check($sformatf("err%0d.lat", i), 32'(lat), 1);
      check($sformatf("err%0d.err", i), 32'(e), 1);
      check($sformatf("err%0d.rdata", i), rd, 32'h00000012);
    end
    do_req(1'b0, 2'd0, 32'h00, 32'h0, lat, rd, e, a0);
    check("err.word0_kept", rd, 32'h11223344);
    do_req(1'b0, 2'd0, 32'h10, 32'h0, lat, rd, e, a0);
    check("err.word4_kept", rd, 32'h1234AAEF);

    // req held high through WAIT and the ack cycle, dropped after the
    // earliest re-acceptance point
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'd0; addr = 32'h10;
    acks2 = 0; acks0 = 0; first2 = 0; second2 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 5) req = 1'b0;
      if (if2.ack) begin
        acks2++;
        if (first2 == 0) first2 = k; else second2 = k;
      end
      if (if0.ack) acks0++;
    end
    check("busy.acks2", 32'(acks2), 2);
    check("busy.first2", 32'(first2), 3);
    check("busy.second2", 32'(second2), 7);
    check("b2b.acks0", 32'(acks0), 3);

    do_req(1'b1, 2'd0, 32'h20, 32'h0BADF00D, lat, rd, e, a0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd0; addr = 32'h20; wdata = 32'h55555555;
    @(negedge clk);
    req = 1'b0;
    check("rstmid.busy_before", 32'(if2.busy), 1);
    #2 reset = 1'b0;
    #1;
    check("rstmid.busy", 32'(if2.busy), 0);
    check("rstmid.ack", 32'(if2.ack), 0);
    check("rstmid.rdata", if2.rdata, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (if2.ack) cnt++;
    end
    check("rstmid.no_ack", 32'(cnt), 0);
    do_req(1'b0, 2'd0, 32'h20, 32'h0, lat, rd, e, a0);
    check("rstmid.old_value", rd, 32'h0BADF00D);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        req = 1'b0;
        reset = 1'b0;
        #1;
        check("rnd.rst.busy2", 32'(if2.busy), 0);
        check("rnd.rst.busy0", 32'(if0.busy), 0);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b1;
      end
      req = ($urandom_range(0, 2) == 0);
      we  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0, 1, 2: size = 2'd0;
        3, 4:    size = 2'd1;
        5, 6:    size = 2'd2;
        default: size = 2'd3;
      endcase
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      else                           addr = 32'($urandom_range(0, 4 * DEPTH + 3));
      wdata = $urandom;
    end
    @(negedge clk);
    req = 1'b0;
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
